// File: rtl/gba_pkg.sv
// gba_pkg: shared EEPROM controller state encoding and DMA-length detection constants.
package gba_pkg;
  typedef enum logic [3:0] {
    INIT, IDLE, BIT2, RD_ADDR, RD_ZERO, RD_HEAD, RD_DATA, WR_ADDR, WR_DATA, WR_ZERO
  } eeprom_state_t;
  localparam logic [16:0] EEP_DMA_R4K  = 17'd9;
  localparam logic [16:0] EEP_DMA_W4K  = 17'd73;
  localparam logic [16:0] EEP_DMA_R64K = 17'd17;
  localparam logic [16:0] EEP_DMA_W64K = 17'd81;
endpackage

// File: rtl/eeprom_bitram.sv
// eeprom_bitram: dual-port save RAM, 1-bit CPU port A and 8-bit RV port B, 1-cycle read latency.
// Bit 0 of each byte-group of eight serial bits lands in byte bit 7, so serial MSB-first data reads back in natural byte order.
module eeprom_bitram #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_a_addr,
  input  logic          i_a_we,
  input  logic          i_a_din,
  output logic          o_a_dout,
  input  logic [AW-4:0] i_b_addr,
  input  logic          i_b_en,
  input  logic          i_b_we,
  input  logic [7:0]    i_b_din,
  output logic [7:0]    o_b_dout
);
  logic [7:0] r_mem [2**(AW-3)];
  logic       r_a_q;
  logic [7:0] r_b_q;
  // Port A is ordered after port B so a same-byte collision keeps the CPU bit.
  always_ff @(posedge clk) begin
    if (i_b_we) r_mem[i_b_addr] <= i_b_din;
    if (i_a_we) r_mem[i_a_addr[AW-1:3]][~i_a_addr[2:0]] <= i_a_din;
    r_a_q <= r_mem[i_a_addr[AW-1:3]][~i_a_addr[2:0]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_b_q <= '0;
    else if (i_b_en) r_b_q <= r_mem[i_b_addr];
  assign o_a_dout = r_a_q;
  assign o_b_dout = r_b_q;
endmodule

// File: rtl/gba_eeprom_ctrl.sv
// gba_eeprom_ctrl: serial GBA EEPROM save emulation (4Kbit/64Kbit) with busy emulation,
// erase sweep after reset and per-region dirty tracking for the RV save-sync side.
module gba_eeprom_ctrl
  import gba_pkg::*;
#(
  parameter int MEM_BLOCKS_LOG2 = 10,
  parameter int SMALL_ABITS     = 6,
  parameter int LARGE_ABITS     = 14,
  parameter int BLOCK_BITS      = 64,
  parameter int HEAD_BITS       = 4,
  parameter int BUSY_READS      = 8,
  parameter int DIRTY_LOG2      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cs,
  input  logic                         model,
  input  logic [16:0]                  dma_eepromcount,
  input  logic                         valid,
  input  logic                         write,
  output logic                         ready,
  input  logic                         din,
  output logic                         dout,
  input  logic                         rv_rd,
  input  logic                         rv_wr,
  input  logic [MEM_BLOCKS_LOG2+2:0]   rv_addr,
  input  logic [7:0]                   rv_wdata,
  output logic [7:0]                   rv_rdata,
  output logic [2**DIRTY_LOG2-1:0]     dirty,
  input  logic [2**DIRTY_LOG2-1:0]     dirty_clr,
  output logic                         init_done,
  output logic                         written
);
  localparam int OW = $clog2(BLOCK_BITS);
  localparam int BW = MEM_BLOCKS_LOG2 + OW;
  localparam int DN = 2**DIRTY_LOG2;
  localparam int CW = $clog2(LARGE_ABITS + HEAD_BITS + 1);
  localparam int UW = $clog2(BUSY_READS + 1);
  localparam logic [CW-1:0] S_LAST = CW'(SMALL_ABITS - 1);
  localparam logic [CW-1:0] L_LAST = CW'(LARGE_ABITS - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HEAD_BITS - 1);

  eeprom_state_t          r_state, w_state_n;
  logic [BW-1:0]          r_iaddr;
  logic [LARGE_ABITS-1:0] r_addr;
  logic [OW-1:0]          r_off;
  logic [CW-1:0]          r_cnt;
  logic [UW-1:0]          r_busy;
  logic [DN-1:0]          r_dirty;
  logic                   r_det, r_big, r_written;
  logic                   w_wr, w_rd, w_addr_last, w_dout, w_commit, w_mem_we, w_q, w_init;

  assign w_init      = r_state == INIT;
  assign w_wr        = cs & valid & write;
  assign w_rd        = cs & valid & ~write;
  assign w_addr_last = r_cnt == (r_big ? L_LAST : S_LAST);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= INIT;
    else r_state <= w_state_n;

  // Any unexpected direction in a command phase falls back to IDLE with dout=1.
  always_comb begin
    w_state_n = r_state;
    w_dout    = 1'b1;
    w_commit  = 1'b0;
    w_mem_we  = 1'b0;
    case (r_state)
      INIT:    if (r_iaddr == '1) w_state_n = IDLE;
      IDLE: begin
        w_dout = r_busy == '0;
        if (w_wr && din) w_state_n = BIT2;
      end
      BIT2:    if (w_wr) w_state_n = din ? RD_ADDR : WR_ADDR; else if (w_rd) w_state_n = IDLE;
      RD_ADDR: if (w_wr) begin if (w_addr_last) w_state_n = RD_ZERO; end else if (w_rd) w_state_n = IDLE;
      WR_ADDR: if (w_wr) begin if (w_addr_last) w_state_n = WR_DATA; end else if (w_rd) w_state_n = IDLE;
      RD_ZERO: if (w_wr) w_state_n = RD_HEAD; else if (w_rd) w_state_n = IDLE;
      RD_HEAD: begin
        w_dout = 1'b0;
        if (w_rd) begin if (r_cnt == H_LAST) w_state_n = RD_DATA; end else if (w_wr) w_state_n = IDLE;
      end
      RD_DATA: begin
        w_dout = w_q;
        if (w_rd) begin if (r_off == '1) w_state_n = IDLE; end else if (w_wr) w_state_n = IDLE;
      end
      WR_DATA: begin
        w_mem_we = w_wr;
        if (w_wr) begin if (r_off == '1) w_state_n = WR_ZERO; end else if (w_rd) w_state_n = IDLE;
      end
      WR_ZERO: begin
        w_commit = w_wr;
        if (valid && cs) w_state_n = IDLE;
      end
      default: w_state_n = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_iaddr   <= '0;
      r_addr    <= '0;
      r_off     <= '0;
      r_cnt     <= '0;
      r_busy    <= '0;
      r_dirty   <= '0;
      r_det     <= 1'b0;
      r_big     <= 1'b0;
      r_written <= 1'b0;
    end else begin
      r_iaddr <= w_init ? r_iaddr + 1'b1 : r_iaddr;
      r_det   <= w_init ? model
               : (dma_eepromcount == EEP_DMA_R4K  || dma_eepromcount == EEP_DMA_W4K)  ? 1'b0
               : (dma_eepromcount == EEP_DMA_R64K || dma_eepromcount == EEP_DMA_W64K) ? 1'b1 : r_det;
      if (r_state == BIT2 && w_wr) begin
        r_addr <= '0;
        r_off  <= '0;
        r_cnt  <= '0;
        r_big  <= r_det;
      end else if ((r_state == RD_ADDR || r_state == WR_ADDR) && w_wr) begin
        r_addr <= {r_addr[LARGE_ABITS-2:0], din};
        r_cnt  <= w_addr_last ? '0 : r_cnt + 1'b1;
      end else if (r_state == RD_HEAD && w_rd) r_cnt <= r_cnt + 1'b1;
      else if ((r_state == RD_DATA && w_rd) || (r_state == WR_DATA && w_wr)) r_off <= r_off + 1'b1;
      r_busy    <= w_commit ? UW'(BUSY_READS)
                 : (r_state == IDLE && w_rd && r_busy != '0) ? r_busy - 1'b1 : r_busy;
      r_dirty   <= (r_dirty & ~dirty_clr) | (w_commit ? DN'(1) << r_addr[MEM_BLOCKS_LOG2-1 -: DIRTY_LOG2] : '0);
      r_written <= w_commit;
    end

  eeprom_bitram #(.AW(BW)) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_a_addr (w_init ? r_iaddr : {r_addr[MEM_BLOCKS_LOG2-1:0], r_off}),
    .i_a_we   (w_init | w_mem_we),
    .i_a_din  (w_init | din),
    .o_a_dout (w_q),
    .i_b_addr (rv_addr),
    .i_b_en   (rv_rd & ~w_init),
    .i_b_we   (rv_wr & ~w_init),
    .i_b_din  (rv_wdata),
    .o_b_dout (rv_rdata)
  );

  assign ready     = valid & rst_n;
  assign dout      = w_dout;
  assign dirty     = r_dirty;
  assign init_done = ~w_init;
  assign written   = r_written;
endmodule

// File: tb/tb_gba_eeprom_ctrl.sv
// tb_gba_eeprom_ctrl: directed serial-protocol and RV-port vectors with hand-computed expectations.
module tb_gba_eeprom_ctrl;
  logic        clk = 0, rst_n = 0, cs = 0, model = 0, valid = 0, write = 0, din = 0;
  logic        rv_rd = 0, rv_wr = 0, ready, dout, init_done, written;
  logic [16:0] dma = 0;
  logic [12:0] rv_addr = 0;
  logic [7:0]  rv_wdata = 0, rv_rdata;
  logic [15:0] dirty, dirty_clr = 0;
  int          total = 0, bad = 0, n_wr = 0;

  localparam logic [63:0] D1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] D2 = 64'hDEADBEEFCAFEF00D;

  gba_eeprom_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .model(model), .dma_eepromcount(dma),
    .valid(valid), .write(write), .ready(ready), .din(din), .dout(dout),
    .rv_rd(rv_rd), .rv_wr(rv_wr), .rv_addr(rv_addr), .rv_wdata(rv_wdata), .rv_rdata(rv_rdata),
    .dirty(dirty), .dirty_clr(dirty_clr), .init_done(init_done), .written(written)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (written) n_wr++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic acc(input logic w, input logic d, output logic o);
    @(negedge clk);
    valid = 1; write = w; din = d;
    #1 o = dout;
    @(negedge clk);
    valid = 0; write = 0; din = 0;
  endtask

  task automatic rv_read(input logic [12:0] a, output logic [7:0] q);
    @(negedge clk);
    rv_rd = 1; rv_addr = a;
    @(negedge clk);
    rv_rd = 0;
    q = rv_rdata;
  endtask

  task automatic send_addr(input int ab, input logic [13:0] a);
    logic o;
    for (int i = ab - 1; i >= 0; i--) acc(1'b1, a[i], o);
  endtask

  task automatic wr_block(input int ab, input logic [13:0] a, input logic [63:0] d, input logic [15:0] clr);
    logic o;
    acc(1'b1, 1'b1, o);
    acc(1'b1, 1'b0, o);
    send_addr(ab, a);
    for (int i = 63; i >= 0; i--) acc(1'b1, d[i], o);
    dirty_clr = clr;
    acc(1'b1, 1'b0, o);
    dirty_clr = '0;
  endtask

  task automatic rd_block(input int ab, input logic [13:0] a, output logic [3:0] h, output logic [63:0] q);
    logic o;
    acc(1'b1, 1'b1, o);
    acc(1'b1, 1'b1, o);
    send_addr(ab, a);
    acc(1'b1, 1'b0, o);
    for (int i = 3; i >= 0; i--) begin acc(1'b0, 1'b0, o); h[i] = o; end
    for (int i = 63; i >= 0; i--) begin acc(1'b0, 1'b0, o); q[i] = o; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic        o;
    logic [7:0]  b, bz;
    logic [3:0]  h;
    logic [63:0] q;
    int          cnt, nw;
    cs = 1; valid = 1;
    #12;
    chk("rst_ready", ready, 0);
    chk("rst_dout", dout, 1);
    chk("rst_rdata", rv_rdata, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_written", written, 0);
    valid = 0;
    @(negedge clk);
    rst_n = 1;
    cnt = 0;
    while (!init_done && cnt < 70000) begin
      @(posedge clk);
      cnt++;
      #1;
    end
    chk("init_cycles", cnt, 65536);
    rv_read(13'h000, b);
    chk("rv_erased", b, 8'hFF);

    dma = 81;
    wr_block(14, 14'h3FF, D1, 16'h0);
    chk("wr64_pulse", n_wr, 1);
    chk("wr64_dirty", dirty, 16'h8000);
    for (int i = 0; i < 8; i++) begin acc(1'b0, 1'b0, o); bz[i] = o; end
    chk("busy_zero", bz, 8'h00);
    acc(1'b0, 1'b0, o);
    chk("busy_end", o, 1);
    q = '0;
    for (int i = 0; i < 8; i++) begin rv_read(13'h1FF8 + 13'(i), b); q = {q[55:0], b}; end
    chk("rv_block", q, D1);

    dma = 17;
    rd_block(14, 14'h3FF, h, q);
    chk("rd64_head", h, 4'h0);
    chk("rd64_data", q, D1);

    dma = 73;
    wr_block(6, 14'h005, D2, 16'h0);
    chk("wr4_dirty", dirty, 16'h8001);
    for (int i = 0; i < 8; i++) acc(1'b0, 1'b0, o);
    dma = 9;
    rd_block(6, 14'h005, h, q);
    chk("rd4_head", h, 4'h0);
    chk("rd4_data", q, D2);

    @(negedge clk);
    rv_wr = 1; rv_addr = 13'h1FF8; rv_wdata = 8'hA5;
    @(negedge clk);
    rv_wr = 0;
    rv_read(13'h1FF8, b);
    chk("rv_wr_back", b, 8'hA5);
    chk("rv_wr_nodirty", dirty, 16'h8001);
    dma = 17;
    rd_block(14, 14'h3FF, h, q);
    chk("rd_after_rvwr", q, 64'hA523456789ABCDEF);

    @(negedge clk);
    valid = 1;
    #1 chk("ready_valid", ready, 1);
    @(negedge clk);
    valid = 0;

    dma = 81;
    nw = n_wr;
    acc(1'b1, 1'b1, o);
    acc(1'b1, 1'b0, o);
    send_addr(14, 14'h010);
    for (int i = 0; i < 10; i++) acc(1'b1, 1'b0, o);
    acc(1'b0, 1'b0, o);
    chk("abort_dout", o, 1);
    chk("abort_nopulse", n_wr, nw);
    chk("abort_dirty", dirty, 16'h8001);
    acc(1'b0, 1'b0, o);
    chk("abort_idle", o, 1);
    rd_block(14, 14'h010, h, q);
    chk("abort_partial", q, 64'h003FFFFFFFFFFFFF);

    wr_block(14, 14'h3FF, D1, 16'h8000);
    chk("set_wins", dirty, 16'h8001);
    @(negedge clk);
    dirty_clr = 16'h0001;
    @(negedge clk);
    dirty_clr = 16'h0;
    chk("clr_only", dirty, 16'h8000);

    rst_n = 0;
    #1;
    chk("mid_rst_dirty", dirty, 0);
    chk("mid_rst_init", init_done, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gba_eeprom_ctrl.md
Name: gba_eeprom_ctrl

Overview:
Parametrised serial EEPROM save-chip controller for the GBA cartridge bus. It supports both the 4Kbit and 64Kbit families, with model detection latched from the DMA transfer length, and emulates the post-write busy period. It also keeps per-region dirty tracking so the RV save-sync firmware flushes only changed regions. It sits between gba_memory (1-bit serial port on data bit 0) and the RV-side 8-bit save port.

Parameters:
MEM_BLOCKS_LOG2, 10, log2 of 64-bit blocks stored (1024 blocks = 8KB); wider addresses wrap modulo this.
SMALL_ABITS, 6, serial address length, 4Kbit model.
LARGE_ABITS, 14, serial address length, 64Kbit model.
BLOCK_BITS, 64, data bits per block (power of two).
HEAD_BITS, 4, don't-care bits before read data.
BUSY_READS, 8, serial reads returning 0 after a write completes.
DIRTY_LOG2, 4, log2 of dirty regions (16 regions).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cs  in  1  EEPROM region selected
model  in  1  default model: 0 = 4Kbit, 1 = 64Kbit
dma_eepromcount  in  17  current DMA3 length, used for detection
valid  in  1  CPU serial access strobe
write  in  1  1 = write access, 0 = read access
ready  out  1  access accepted
din  in  1  serial data in (bit 0)
dout  out  1  serial data out
rv_rd  in  1  RV byte read
rv_wr  in  1  RV byte write
rv_addr  in  MEM_BLOCKS_LOG2+3  RV byte address
rv_wdata  in  8  RV write data
rv_rdata  out  8  RV read data, valid 1 cycle after rv_rd
dirty  out  2**DIRTY_LOG2  per-region dirty flags
dirty_clr  in  2**DIRTY_LOG2  clear mask; RV acknowledges flush
init_done  out  1  erase sweep finished
written  out  1  1-cycle pulse when a CPU block write commits

Behaviour:
- Reset values: ready=0, dout=1, rv_rdata=0, dirty=0, init_done=0, written=0. FSM enters INIT; detected model is taken from `model`.
- INIT: sweeps every bit address, one per cycle, writing 1 (erased). init_done rises on the cycle after the last address. CPU accesses during INIT get ready=valid and dout=1, and are otherwise ignored. RV accesses are blocked (rv_rdata=0, writes dropped).
- ready = valid outside reset; there are no wait states.
- Model detection is sticky.
  - dma_eepromcount 9 or 73 latches model 0; 17 or 81 latches model 1.
  - Any other value keeps the current latch.
  - The address bit count cnt is taken from the latch at the BIT2 accept.
- FSM advances only on cs & valid.
  - IDLE: dout=1, or 0 while busy_cnt>0 (a read decrements busy_cnt). A write with din=1 goes to BIT2.
  - BIT2 (write): din=1 goes to RD_ADDR, din=0 goes to WR_ADDR. Clears addr and bit offset.
  - RD_ADDR/WR_ADDR: shift in ABITS bits MSB-first, then go to RD_ZERO or WR_DATA.
  - RD_ZERO (write): goes to RD_HEAD.
  - RD_HEAD: HEAD_BITS reads with dout=0, then RD_DATA.
  - RD_DATA: BLOCK_BITS reads, MSB first, return stored bits; then IDLE.
  - WR_DATA: BLOCK_BITS writes store din at {addr,off}, then WR_ZERO.
  - WR_ZERO (write, any din): goes to IDLE, pulses written, sets busy_cnt=BUSY_READS, and sets dirty[addr[MEM_BLOCKS_LOG2-1 -: DIRTY_LOG2]].
- Protocol error: a read during BIT2, *_ADDR, RD_ZERO, WR_DATA or WR_ZERO aborts to IDLE.
  - If the error hits during WR_DATA, bits already written stay written, with no written pulse and no dirty set.
  - The aborting read returns 1.
  - A write during RD_HEAD/RD_DATA aborts to IDLE with no other effect.
- Memory read latency is 1 cycle. Bit N is prefetched when the offset advances, so dout is valid at the next valid strobe (≥2 cycles apart, guaranteed by gba_memory).
- RV port:
  - rv_rdata is registered and holds until the next rv_rd.
  - rv_wr does not set dirty.
  - Same-cycle collision on the same byte: the CPU bit write wins; the RV byte is written with that bit overridden.
- dirty_clr and a same-cycle set of the same region: set wins.
- Reset mid-operation: asynchronous return to INIT. Memory contents are re-erased, and dirty is cleared.

Decomposition:
- gba_pkg gets the eeprom_state_t enum (INIT, IDLE, BIT2, RD_ADDR, RD_ZERO, RD_HEAD, RD_DATA, WR_ADDR, WR_DATA, WR_ZERO) and the DMA length constants EEP_DMA_R4K=9, EEP_DMA_W4K=73, EEP_DMA_R64K=17, EEP_DMA_W64K=81.
- One sub-module, eeprom_bitram: a true dual-port RAM with a 1-bit port A and an 8-bit port B, 1-cycle latency, mapped to mem_eeprom on M138K and inferred otherwise.

Test Plan:
- Reset then run the sweep: init_done rises after 65536 cycles; an RV read at byte 0x000 returns 0xFF.
- dma_eepromcount=81, then write block 0x3FF with data 0x0123456789ABCDEF (14-bit address). Response: written pulses, dirty[15]=1, and the next 8 reads return 0 before 1. Then an RV read of bytes 0x1FF8..0x1FFF returns 01 23 45 67 89 AB CD EF.
- dma_eepromcount=17, then a read of block 0x3FF: the first 4 reads return 0, and the following 64 reads return the block's 64 bits MSB-first.
- dma_eepromcount=73, then write block 0x05 with 6-bit address 000101: dirty[0] is set. A subsequent 4K read of block 0x05 returns the same data.
- A write aborted after 10 data bits, followed by a read: dout=1, no written pulse, dirty unchanged, FSM back in IDLE.
- dirty_clr=16'h8000 in the same cycle as the WR_ZERO commit to block 0x3FF: dirty[15] remains 1.
